// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the RISC-V run/debug controller: FSM states, stop causes
// and the canonical NOP encoding used for end-of-program detection.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESETTING = 3'd1,
        ST_RUN       = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_STEP      = 3'd4,
        ST_DONE      = 3'd5
    } run_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE   = 3'd0,
        CAUSE_HALT   = 3'd1,
        CAUSE_BREAK  = 3'd2,
        CAUSE_END    = 3'd3,
        CAUSE_MAXCYC = 3'd4
    } stop_cause_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/riscv_run_ctrl.sv
// Run/debug sequencer for the single-cycle RISC-V core: holds the core in reset,
// gates its state updates, counts executed cycles and handles halt/break/step.
module riscv_run_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 3,
    parameter int IDLE_LIMIT   = 4,
    parameter int MAX_CYCLES   = 20,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    output logic             core_reset,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic [2:0]       stop_cause,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int NOP_W = $clog2(IDLE_LIMIT + 1);

    run_state_e       state;
    stop_cause_e      cause;
    logic [RST_W-1:0] rst_cnt;
    logic [NOP_W-1:0] nop_cnt;
    logic [CNT_W-1:0] cycle_cnt;
    logic             bp_mask;

    logic             bp_hit;
    logic             stop_now;
    logic [CNT_W-1:0] cnt_next;
    logic [NOP_W-1:0] nop_next;
    logic             hit_end;
    logic             hit_max;
    logic             fin;
    stop_cause_e      fin_cause;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The breakpoint is masked for the first cycle after a resume so the PC
    // that caused the pause can execute.
    always_comb begin
        bp_hit    = bp_en && !bp_mask && (pc == bp_addr);
        stop_now  = halt_req || bp_hit;
        core_en   = ((state == ST_RUN) && !stop_now) || (state == ST_STEP);
        cnt_next  = sat_inc(cycle_cnt);
        nop_next  = (instr == NOP_INSTR) ? nop_cnt + NOP_W'(1) : '0;
        hit_end   = (nop_next == NOP_W'(IDLE_LIMIT));
        hit_max   = (MAX_CYCLES != 0) && (cnt_next == CNT_W'(MAX_CYCLES));
        fin       = hit_end || hit_max;
        fin_cause = hit_end ? CAUSE_END : CAUSE_MAXCYC;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cause     <= CAUSE_NONE;
            rst_cnt   <= '0;
            nop_cnt   <= '0;
            cycle_cnt <= '0;
            bp_mask   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_RESETTING;
                        cause     <= CAUSE_NONE;
                        rst_cnt   <= '0;
                        nop_cnt   <= '0;
                        cycle_cnt <= '0;
                        bp_mask   <= 1'b0;
                    end
                end
                ST_RESETTING: begin
                    if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
                        state   <= ST_RUN;
                        rst_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                ST_RUN: begin
                    bp_mask <= 1'b0;
                    if (stop_now) begin
                        state <= ST_PAUSED;
                        cause <= halt_req ? CAUSE_HALT : CAUSE_BREAK;
                    end else begin
                        cycle_cnt <= cnt_next;
                        nop_cnt   <= nop_next;
                        if (fin) begin
                            state <= ST_DONE;
                            cause <= fin_cause;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (step_req) begin
                        state <= ST_STEP;
                    end else if (start) begin
                        state   <= ST_RUN;
                        bp_mask <= 1'b1;
                    end
                end
                ST_STEP: begin
                    cycle_cnt <= cnt_next;
                    nop_cnt   <= nop_next;
                    if (fin) begin
                        state <= ST_DONE;
                        cause <= fin_cause;
                    end else begin
                        state <= ST_PAUSED;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign core_reset  = (state == ST_IDLE) || (state == ST_RESETTING);
    assign busy        = (state != ST_IDLE) && (state != ST_DONE);
    assign done        = (state == ST_DONE);
    assign stop_cause  = cause;
    assign cycle_count = cycle_cnt;

endmodule

// File: doc/riscv_run_ctrl.md
Name: riscv_run_ctrl

Overview:
Run/debug controller that sequences the single-cycle RISC-V core (RiscV_SingleCycle).
- Drives the core's reset and a clock enable that gates PC and state updates.
- Counts executed cycles and detects end of program.
- Supports halt, PC breakpoint and single-step.
- Sits between the core and the test/debug host; gives benches and the FPGA top a deterministic start, stop and status.

Parameters:
RESET_CYCLES, 3, number of cycles core_reset is held after start (≥1).
IDLE_LIMIT, 4, consecutive executed NOPs (0x00000013) that mean end of program (≥1).
MAX_CYCLES, 20, executed-cycle limit; 0 disables.
CNT_W, 32, width of cycle_count.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset of this controller.
start  in  1  launch from IDLE/DONE; resume from PAUSED.
halt_req  in  1  request stop before the current instruction executes.
step_req  in  1  execute exactly one instruction while PAUSED.
bp_en  in  1  breakpoint enable.
bp_addr  in  32  breakpoint PC.
pc  in  32  current core PC.
instr  in  32  current core instruction.
core_reset  out  1  reset to the core.
core_en  out  1  core state-update enable (combinational).
busy  out  1  high when state is not IDLE and not DONE.
done  out  1  sticky end-of-run flag.
stop_cause  out  3  0 NONE, 1 HALT, 2 BREAK, 3 END, 4 MAXCYC.
cycle_count  out  CNT_W  executed-cycle counter.

Behaviour:
- Clock and reset: one clock. reset is asynchronous and active-high.
- Reset values:
  - state IDLE, core_reset=1, core_en=0, busy=0, done=0, stop_cause=0, cycle_count=0.
  - Internal reset-cycle and NOP counters are 0.
- Reset asserted mid-run returns the block to these values immediately, without waiting for a clock edge.
- State IDLE: core_reset=1. start → RESETTING; clears cycle_count, done and stop_cause.
- State RESETTING: core_reset=1, core_en=0 for exactly RESET_CYCLES clocks, then RUN with core_reset=0.
- State RUN:
  - core_en = 1 unless stop_now.
  - stop_now is combinational on the current pc, instr and halt_req. Priority: halt_req, then bp_en && pc==bp_addr.
  - On stop_now the instruction does not execute. Next state is PAUSED, with stop_cause HALT or BREAK.
- Executed cycle (any cycle with core_en=1):
  - cycle_count increments and saturates at all-ones.
  - NOP counter increments if instr==0x00000013; otherwise it clears.
- End of run (checked after the executed cycle):
  - NOP counter reaches IDLE_LIMIT → DONE, cause END.
  - Otherwise, MAX_CYCLES≠0 and the new cycle_count equals MAX_CYCLES → DONE, cause MAXCYC.
  - END beats MAXCYC when both hit in the same cycle.
- State PAUSED: core_en=0, core_reset=0.
  - step_req → STEP.
  - start → RUN, with the breakpoint masked for the first RUN cycle so the same PC does not re-trigger.
  - halt_req is ignored. step_req beats start when both are asserted.
- State STEP:
  - core_en=1 for exactly one cycle. Breakpoint and halt_req are ignored.
  - Then PAUSED, or DONE if an end condition fires.
  - stop_cause is left unchanged unless the step causes DONE.
- State DONE:
  - core_en=0, core_reset=0 (core state stays readable), done=1.
  - start → RESETTING (rerun).
- Ignored inputs: start in RESETTING or RUN. start together with halt_req in RUN: halt wins.
- All outputs except core_en are registered or decoded from state.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum (IDLE, RESETTING, RUN, PAUSED, STEP, DONE);
  - stop_cause enum (3-bit, encoding above);
  - NOP constant 32'h00000013.
- No sub-module is warranted: the counters and the FSM stay in riscv_run_ctrl.
- Integrate by driving RiscV_SingleCycle.reset from core_reset and gating its PC/register/memory write enables with core_en.

Test Plan:
- Reset, then start pulse, RESET_CYCLES=3 → core_reset high for exactly 3 clocks after start, then core_en=1 and busy=1.
- 5 non-NOP instrs then NOPs, IDLE_LIMIT=4, MAX_CYCLES=0 → DONE after the 9th executed cycle: done=1, stop_cause=3, cycle_count=9.
- Breakpoint and step:
  - bp_en=1, bp_addr=0x10, pc sequence 0,4,8,0xC,0x10 → core_en=0 when pc=0x10, PAUSED, stop_cause=2, cycle_count=4.
  - step_req → one core_en cycle, cycle_count=5, back to PAUSED.
  - start → RUN, no re-hit at the masked PC.
- halt_req asserted together with a bp match at cycle_count=7 → stop_cause=1, cycle_count stays 7.
- MAX_CYCLES=20, no NOPs → DONE at cycle_count=20, stop_cause=4; a later start → RESETTING with cycle_count=0.
- Async reset asserted between clock edges during RUN → core_reset=1, core_en=0, done=0, cycle_count=0 before the next clock edge.
